// File: rtl/mem_pkg.sv
// Shared types and sizing constants for the pipelined word memory
// and anything that reuses its response delay line.
package mem_pkg;

  localparam int MEM_ADDR_W          = 16;
  localparam int MEM_DATA_W          = 16;
  localparam int MEM_DEFAULT_LATENCY = 4;
  localparam int MEM_MAX_LATENCY     = 8;

  typedef struct packed {
    logic                  valid;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] data;
  } mem_stage_t;

endpackage

// File: rtl/mem_resp_pipe.sv
// Fixed-depth delay line of {valid, addr, data} records with a
// synchronous clear; one record enters and one leaves every clock.
import mem_pkg::*;

module mem_resp_pipe #(
  parameter int LATENCY = MEM_DEFAULT_LATENCY
) (
  input  logic       clk,
  input  logic       rst,
  input  mem_stage_t i_stage,
  output mem_stage_t o_stage
);

  mem_stage_t r_stg [LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LATENCY; k++) begin
        r_stg[k] <= '0;
      end
    end else begin
      r_stg[0] <= i_stage;
      for (int k = 1; k < LATENCY; k++) begin
        r_stg[k] <= r_stg[k-1];
      end
    end
  end

  assign o_stage = r_stg[LATENCY-1];

endmodule

// File: rtl/mem_responder_mc.sv
// Fully pipelined word memory: one request per clock, read data
// returned a fixed LATENCY cycles after acceptance, in order.
import mem_pkg::*;

module mem_responder_mc #(
  parameter int ADDR_W  = MEM_ADDR_W,
  parameter int DATA_W  = MEM_DATA_W,
  parameter int LATENCY = MEM_DEFAULT_LATENCY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic [ADDR_W-1:0] resp_addr,
  output logic [3:0]        pending
);

  localparam int WORDS = 1 << (ADDR_W - 1);

  generate
    if (LATENCY < 1 || LATENCY > MEM_MAX_LATENCY) begin : g_bad_lat
      $error("mem_responder_mc: LATENCY out of range 1..8");
    end
    if (ADDR_W > MEM_ADDR_W || DATA_W > MEM_DATA_W) begin : g_bad_w
      $error("mem_responder_mc: width exceeds stage record");
    end
  endgenerate

  logic [DATA_W-1:0]   r_mem [WORDS];
  logic [ADDR_W-2:0]   w_widx;
  logic [DATA_W-1:0]   w_rdata;
  logic                w_rd_acc;
  logic                w_unused_a0;
  mem_stage_t          w_in;
  mem_stage_t          w_out;
  logic [3:0]          r_pending;

  assign w_widx      = addr[ADDR_W-1:1];
  assign w_unused_a0 = addr[0];
  assign w_rdata     = r_mem[w_widx];
  assign w_rd_acc    = enable & ~wr & ~rst;

  // Storage is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (!rst && enable && wr) begin
      r_mem[w_widx] <= data_in;
    end
  end

  always_comb begin
    w_in       = '0;
    w_in.valid = w_rd_acc;
    w_in.addr  = MEM_ADDR_W'({w_widx, 1'b0});
    w_in.data  = MEM_DATA_W'(w_rdata);
  end

  mem_resp_pipe #(
    .LATENCY (LATENCY)
  ) u_pipe (
    .clk     (clk),
    .rst     (rst),
    .i_stage (w_in),
    .o_stage (w_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
    end else begin
      r_pending <= r_pending + 4'(w_rd_acc) - 4'(w_out.valid);
    end
  end

  assign data_valid = w_out.valid;
  assign data_out   = w_out.valid ? w_out.data[DATA_W-1:0] : '0;
  assign resp_addr  = w_out.valid ? w_out.addr[ADDR_W-1:0] : '0;
  assign pending    = r_pending;

endmodule
